// File: rtl/pwm_dac_multi_if.sv
// Shadow-register load port for pwm_dac_multi: valid/ready write of one channel value.
interface pwm_dac_multi_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 2
);
  logic             load_valid;
  logic             load_ready;
  logic [CW-1:0]    load_chan;
  logic [WIDTH-1:0] load_data;

  modport master (
    output load_valid,
    output load_chan,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_chan,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/pwm_dac_multi.sv
// NCH-channel PWM DAC sharing one period counter, with double-buffered channel values.
// Define PWM_DAC_SIGMA_DELTA_EN to build per-channel first-order sigma-delta mode.
module pwm_dac_multi #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned CW    = 2
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              enable,
  pwm_dac_multi_if.slave    load,
  input  logic [NCH-1:0]    mode,
  output logic [NCH-1:0]    dac_bit,
  output logic              period_tick,
  output logic              load_err
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } ready_state_e;

  ready_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] shadow_q [NCH];
  logic [WIDTH-1:0] shadow_d [NCH];
  logic [WIDTH-1:0] active_q [NCH];
  logic [WIDTH-1:0] active_d [NCH];
  logic [NCH-1:0]   dac_q, dac_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             ready;
  logic             accept;
  logic             boundary;
  logic             chan_ok;
  logic [2**CW-1:0] chan_map;

`ifdef PWM_DAC_SIGMA_DELTA_EN
  logic [WIDTH-1:0] acc_q [NCH];
  logic [WIDTH-1:0] acc_d [NCH];
  logic [WIDTH:0]   sd_sum [NCH];
`else
  logic unused_mode;
  assign unused_mode = ^mode;
`endif

  // Ready is held off for one cycle after reset releases.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign ready = (state_q == ST_RUN);

  // Decoded map of legal channel indices; avoids indexing past NCH.
  always_comb begin
    chan_map = '0;
    for (int unsigned i = 0; i < 2**CW; i++) begin
      chan_map[i] = (i < NCH);
    end
  end

  assign accept   = load.load_valid & ready;
  assign chan_ok  = chan_map[load.load_chan];
  assign boundary = enable & (count_q == CNT_MAX);

  always_comb begin
    count_d = enable ? count_q + 1'b1 : count_q;
    tick_d  = boundary;
    err_d   = accept & ~chan_ok;
    dac_d   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      shadow_d[i] = shadow_q[i];
      if (accept && (load.load_chan == CW'(i))) begin
        shadow_d[i] = load.load_data;
      end
      // Transfer takes the pre-edge shadow, so a same-cycle load waits a period.
      active_d[i] = boundary ? shadow_q[i] : active_q[i];
      dac_d[i]    = enable & (count_q < active_q[i]);
`ifdef PWM_DAC_SIGMA_DELTA_EN
      sd_sum[i] = {1'b0, acc_q[i]} + {1'b0, active_q[i]};
      acc_d[i]  = acc_q[i];
      if (enable && mode[i]) begin
        acc_d[i] = sd_sum[i][WIDTH-1:0];
        dac_d[i] = sd_sum[i][WIDTH];
      end
`endif
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q <= ST_INIT;
      count_q <= '0;
      dac_q   <= '0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
`ifdef PWM_DAC_SIGMA_DELTA_EN
        acc_q[i]    <= '0;
`endif
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dac_q   <= dac_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
`ifdef PWM_DAC_SIGMA_DELTA_EN
        acc_q[i]    <= acc_d[i];
`endif
      end
    end
  end

  assign load.load_ready = ready;
  assign dac_bit         = dac_q;
  assign period_tick     = tick_q;
  assign load_err        = err_q;

endmodule

// File: tb/tb_pwm_dac_multi.sv
// Bench for pwm_dac_multi: NCH=4 and NCH=3 instances driven identically, checked against a reference model.
module tb_pwm_dac_multi;
  localparam int unsigned W   = 8;
  localparam int unsigned CW  = 2;
  localparam int unsigned PER = 256;

  logic aclk = 1'b0;
  always #4 aclk = ~aclk;

  logic         reset;
  logic         enable;
  logic [3:0]   mode;
  logic         lv;
  logic [1:0]   lc;
  logic [7:0]   ld;
  logic [3:0]   dac4;
  logic [2:0]   dac3;
  logic         tick4, tick3, err4, err3;

  pwm_dac_multi_if #(.WIDTH(W), .CW(CW)) if4 ();
  pwm_dac_multi_if #(.WIDTH(W), .CW(CW)) if3 ();

  assign if4.load_valid = lv;
  assign if4.load_chan  = lc;
  assign if4.load_data  = ld;
  assign if3.load_valid = lv;
  assign if3.load_chan  = lc;
  assign if3.load_data  = ld;

  pwm_dac_multi #(.WIDTH(W), .NCH(4), .CW(CW)) dut4 (
    .aclk(aclk), .reset(reset), .enable(enable), .load(if4.slave),
    .mode(mode), .dac_bit(dac4), .period_tick(tick4), .load_err(err4)
  );

  pwm_dac_multi #(.WIDTH(W), .NCH(3), .CW(CW)) dut3 (
    .aclk(aclk), .reset(reset), .enable(enable), .load(if3.slave),
    .mode(mode[2:0]), .dac_bit(dac3), .period_tick(tick3), .load_err(err3)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned nch_of [2] = '{4, 3};
  int unsigned m_count [2];
  int unsigned m_sh    [2][4];
  int unsigned m_act   [2][4];
  int unsigned m_acc   [2][4];
  int unsigned m_ready [2];
  int unsigned e_dac   [2];
  int unsigned e_tick  [2];
  int unsigned e_err   [2];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Advance one clock: model the edge from the inputs as driven, then compare both DUTs.
  task automatic step();
    int unsigned n_count [2];
    int unsigned n_sh    [2][4];
    int unsigned n_act   [2][4];
    int unsigned n_acc   [2][4];
    int unsigned n_ready [2];
    int unsigned n_dac   [2];
    int unsigned n_tick  [2];
    int unsigned n_err   [2];
    bit acc_ok, bnd, bit_v;
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < 4; ch++) begin
        n_sh[d][ch]  = 0;
        n_act[d][ch] = 0;
        n_acc[d][ch] = 0;
      end
      if (reset) begin
        n_count[d] = 0; n_ready[d] = 0; n_dac[d] = 0; n_tick[d] = 0; n_err[d] = 0;
      end else begin
        acc_ok     = lv && (m_ready[d] != 0);
        bnd        = enable && (m_count[d] == PER - 1);
        n_ready[d] = 1;
        n_err[d]   = (acc_ok && (int'(lc) >= nch_of[d])) ? 1 : 0;
        n_tick[d]  = bnd ? 1 : 0;
        n_count[d] = enable ? (m_count[d] + 1) % PER : m_count[d];
        n_dac[d]   = 0;
        for (int ch = 0; ch < 4; ch++) begin
          if (ch < int'(nch_of[d])) begin
            n_sh[d][ch]  = (acc_ok && int'(lc) == ch) ? int'(ld) : m_sh[d][ch];
            n_act[d][ch] = bnd ? m_sh[d][ch] : m_act[d][ch];
            n_acc[d][ch] = m_acc[d][ch];
            bit_v = enable && (m_count[d] < m_act[d][ch]);
`ifdef PWM_DAC_SIGMA_DELTA_EN
            if (enable && mode[ch]) begin
              bit_v        = (m_acc[d][ch] + m_act[d][ch]) >= PER;
              n_acc[d][ch] = (m_acc[d][ch] + m_act[d][ch]) % PER;
            end
`endif
            if (bit_v) n_dac[d] = n_dac[d] | (1 << ch);
          end
        end
      end
    end
    @(posedge aclk);
    @(negedge aclk);
    m_count = n_count; m_sh = n_sh; m_act = n_act; m_acc = n_acc;
    m_ready = n_ready; e_dac = n_dac; e_tick = n_tick; e_err = n_err;
    check_eq("dac4",   dac4,           e_dac[0]);
    check_eq("dac3",   dac3,           e_dac[1]);
    check_eq("tick4",  tick4,          e_tick[0]);
    check_eq("tick3",  tick3,          e_tick[1]);
    check_eq("err4",   err4,           e_err[0]);
    check_eq("err3",   err3,           e_err[1]);
    check_eq("ready4", if4.load_ready, m_ready[0]);
    check_eq("ready3", if3.load_ready, m_ready[1]);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic wait_count(input int unsigned c);
    for (int k = 0; k < 600 && m_count[0] != c; k++) step();
    if (m_count[0] != c) check_eq("wait_count_timeout", m_count[0], c);
  endtask

  task automatic load1(input int unsigned ch, input int unsigned data);
    lv = 1'b1; lc = 2'(ch); ld = 8'(data);
    step();
    lv = 1'b0;
  endtask

  // Find a period_tick, then count high output cycles over the following full period.
  task automatic measure(input int ch, input int unsigned exp4, input int unsigned exp3);
    int unsigned ones4, ones3;
    for (int k = 0; k < 300 && !tick4; k++) step();
    if (!tick4) check_eq("tick_timeout", tick4, 1);
    ones4 = 0; ones3 = 0;
    repeat (PER) begin
      step();
      ones4 += dac4[ch];
      if (ch < 3) ones3 += dac3[ch];
    end
    check_eq($sformatf("ones4_ch%0d", ch), ones4, exp4);
    if (ch < 3) check_eq($sformatf("ones3_ch%0d", ch), ones3, exp3);
  endtask

  initial begin
    int unsigned nticks;
    reset = 1'b1; enable = 1'b1; mode = '0; lv = 1'b0; lc = '0; ld = '0;
    do_reset(3);

    // Idle run: all outputs low, a tick every period.
    nticks = 0;
    repeat (1024) begin
      step();
      nticks += tick4;
    end
    check_eq("ticks_1024", nticks, 4);

    wait_count(10);
    load1(1, 64);
    measure(1, 64, 64);

    wait_count(255);
    load1(2, 200);
    measure(2, 0, 0);
    measure(2, 200, 200);

    load1(3, 5);
    check_eq("err3_pulse", err3, 1);
    check_eq("err4_quiet", err4, 0);
    measure(3, 5, 0);

    load1(1, 100);
    measure(1, 100, 100);
    wait_count(77);
    enable = 1'b0;
    repeat (50) step();
    enable = 1'b1;
    wait_count(130);
    do_reset(2);
    repeat (2) step();
    measure(1, 0, 0);
    measure(2, 0, 0);

`ifdef PWM_DAC_SIGMA_DELTA_EN
    mode = 4'b0001;
    load1(0, 85);
    measure(0, 85, 85);
    measure(0, 85, 85);
    load1(0, 128);
    measure(0, 128, 128);
    mode = '0;
`endif

    repeat (3000) begin
      lv     = ($urandom_range(0, 3) == 0);
      lc     = 2'($urandom);
      ld     = 8'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      mode   = 4'($urandom);
      reset  = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; lv = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
